fnd_scan_controller: RTL and testbench

- Downstream display stage of the stopwatch: consumes the stopwatch time counters and drives the 4-digit common-anode 7-segment FND (fnd_com / fnd_data).
- Time-multiplexes four digits at a fixed scan rate.
- sw0 selects the displayed pair: sec.msec or hour:min.
- Blinks the centre decimal point at 1 Hz from the msec count.

---
 rtl/fnd_scan_controller.sv | 171 +++++++++++++++++
 tb/tb_fnd_scan_controller.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_controller.sv
// Display back end of the stopwatch: time-multiplexes a 4-digit common-anode FND,
// showing sec.msec or hour:min, with a 1 Hz blinking centre decimal point.
module fnd_scan_controller #(
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_THRESH = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw0,
    input  logic [6:0] msec,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [4:0] hour,
    output logic [3:0] fnd_com,
    output logic [7:0] fnd_data
);

    localparam int                 CNT_W     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [6:0]         BLINK_LIM = 7'(BLINK_THRESH);

    function automatic logic [6:0] sat99(input logic [6:0] v);
        logic [6:0] r;
        if (v > 7'd99) begin
            r = 7'd99;
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic [3:0] ones_of(input logic [6:0] v);
        logic [6:0] r;
        r = v % 7'd10;
        return r[3:0];
    endfunction

    function automatic logic [3:0] tens_of(input logic [6:0] v);
        logic [6:0] q;
        q = v / 7'd10;
        return q[3:0];
    endfunction

    // Active-low segment pattern for a decimal digit, dp off.
    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    logic             sync1_r;
    logic             sync2_r;
    logic [CNT_W-1:0] scan_cnt_r;
    logic             tick_s;
    logic [1:0]       digit_sel_r;
    logic [6:0]       pair_lo_s;
    logic [6:0]       pair_hi_s;
    logic [3:0]       digit_s;
    logic [3:0]       com_s;
    logic [7:0]       seg_s;
    logic             dp_on_s;
    logic [7:0]       data_s;
    logic [3:0]       com_r;
    logic [7:0]       data_r;

    // Two-flop synchroniser for the asynchronous mode switch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= sw0;
            sync2_r <= sync1_r;
        end
    end

    assign tick_s = (scan_cnt_r == CNT_LAST);

    // Slot timer: one tick per SCAN_DIV clocks, issued on the wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_r <= '0;
        end else if (tick_s) begin
            scan_cnt_r <= '0;
        end else begin
            scan_cnt_r <= scan_cnt_r + 1'b1;
        end
    end

    // Digit select advances once per slot; mode changes never touch it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_sel_r <= 2'd0;
        end else if (tick_s) begin
            digit_sel_r <= digit_sel_r + 2'd1;
        end else begin
            digit_sel_r <= digit_sel_r;
        end
    end

    // Select the displayed pair, saturate to 99 and pick the current digit.
    always_comb begin
        pair_lo_s = 7'd0;
        pair_hi_s = 7'd0;
        digit_s   = 4'd0;
        com_s     = 4'b1111;
        if (sync2_r) begin
            pair_lo_s = sat99({1'b0, min});
            pair_hi_s = sat99({2'b00, hour});
        end else begin
            pair_lo_s = sat99(msec);
            pair_hi_s = sat99({1'b0, sec});
        end
        case (digit_sel_r)
            2'd0: begin
                digit_s = ones_of(pair_lo_s);
                com_s   = 4'b1110;
            end
            2'd1: begin
                digit_s = tens_of(pair_lo_s);
                com_s   = 4'b1101;
            end
            2'd2: begin
                digit_s = ones_of(pair_hi_s);
                com_s   = 4'b1011;
            end
            2'd3: begin
                digit_s = tens_of(pair_hi_s);
                com_s   = 4'b0111;
            end
            default: begin
                digit_s = 4'd0;
                com_s   = 4'b1111;
            end
        endcase
    end

    // The centre dp blinks from the raw hundredths count in both modes.
    always_comb begin
        seg_s   = seg7(digit_s);
        dp_on_s = (digit_sel_r == 2'd2) && (msec < BLINK_LIM);
        data_s  = {~dp_on_s, seg_s[6:0]};
    end

    // Registered outputs, blanked while in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            com_r  <= 4'b1111;
            data_r <= 8'hFF;
        end else begin
            com_r  <= com_s;
            data_r <= data_s;
        end
    end

    assign fnd_com  = com_r;
    assign fnd_data = data_r;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Scoreboard bench for fnd_scan_controller with a short scan slot (SCAN_DIV = 4).
module tb_fnd_scan_controller;

    localparam int DIV = 4;

    logic       clk;
    logic       rst;
    logic       sw0;
    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [3:0] fnd_com;
    logic [7:0] fnd_data;

    typedef struct {
        int         stamp;
        logic [3:0] com;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   rbase;
    int   checks;
    int   errors;

    fnd_scan_controller #(.SCAN_DIV(DIV), .BLINK_THRESH(50)) dut (
        .clk      (clk),
        .rst      (rst),
        .sw0      (sw0),
        .msec     (msec),
        .sec      (sec),
        .min      (min),
        .hour     (hour),
        .fnd_com  (fnd_com),
        .fnd_data (fnd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle stamp: value N after the N-th rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int digit_at(input int c);
        return ((c - rbase - 1) / DIV) % 4;
    endfunction

    function automatic logic [3:0] com_for(input int d);
        logic [3:0] r;
        case (d)
            0:       r = 4'b1110;
            1:       r = 4'b1101;
            2:       r = 4'b1011;
            default: r = 4'b0111;
        endcase
        return r;
    endfunction

    task automatic push_blank(input int first, input int last);
        for (int c = first; c <= last; c++) sb.push_back('{c, 4'b1111, 8'hFF});
    endtask

    task automatic push_window(input int first, input int last,
                               input logic [7:0] s0, input logic [7:0] s1,
                               input logic [7:0] s2, input logic [7:0] s3);
        logic [7:0] t [4];
        t[0] = s0; t[1] = s1; t[2] = s2; t[3] = s3;
        for (int c = first; c <= last; c++) begin
            int d;
            d = digit_at(c);
            sb.push_back('{c, com_for(d), t[d]});
        end
    endtask

    task automatic wait_cyc(input int n);
        do begin
            @(posedge clk);
            #2;
        end while (cyc < n);
    endtask

    // Monitor: compare every expectation stamped for the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].stamp <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (e.stamp < cyc) begin
                errors++;
                $display("FAIL missed_slot stamp=%0d now=%0d", e.stamp, cyc);
            end else if (fnd_com !== e.com || fnd_data !== e.data) begin
                errors++;
                $display("FAIL scan cyc=%0d got com=%b data=%h expected com=%b data=%h",
                         cyc, fnd_com, fnd_data, e.com, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int f;
        int r2;
        cyc = 0; rbase = 0; checks = 0; errors = 0;
        rst = 1'b1; sw0 = 1'b0;
        msec = 7'd37; sec = 6'd42; min = 6'd0; hour = 5'd0;

        // Reset held for 100 ns: blank throughout, then digit 0 on the first edge.
        push_blank(1, 10);
        wait_cyc(10);
        rst = 1'b0;
        rbase = cyc;
        push_window(rbase + 1, rbase + 20, 8'hF8, 8'hB0, 8'h24, 8'h99);
        wait_cyc(rbase + 20);

        // Blink threshold: msec 50 -> dp off, msec 49 -> dp on.
        c0 = cyc;
        msec = 7'd50; sec = 6'd5;
        push_window(c0 + 1, c0 + 16, 8'hC0, 8'h92, 8'h92, 8'hC0);
        wait_cyc(c0 + 16);
        c0 = cyc;
        msec = 7'd49;
        push_window(c0 + 1, c0 + 16, 8'h90, 8'h99, 8'h12, 8'hC0);
        wait_cyc(c0 + 16);

        // Mode switch: two more mode-0 cycles through the synchroniser, then hour:min.
        c0 = cyc;
        msec = 7'd10; hour = 5'd23; min = 6'd9; sw0 = 1'b1;
        push_window(c0 + 1, c0 + 2, 8'hC0, 8'hF9, 8'h12, 8'hC0);
        push_window(c0 + 3, c0 + 18, 8'h90, 8'hC0, 8'h30, 8'hA4);
        wait_cyc(c0 + 18);

        // Saturation of an out-of-range msec (checked once the mode has settled).
        c0 = cyc;
        sw0 = 1'b0; msec = 7'd127; sec = 6'd42;
        push_window(c0 + 3, c0 + 18, 8'h90, 8'h90, 8'hA4, 8'h99);
        wait_cyc(c0 + 18);

        // Reset asserted during a digit-2 slot.
        f = 0;
        while (digit_at(cyc) != 2 && f < 20) begin
            wait_cyc(cyc + 1);
            f++;
        end
        checks++;
        if (digit_at(cyc) != 2 || fnd_com !== 4'b1011) begin
            errors++;
            $display("FAIL pre_reset_slot got com=%b expected com=1011", fnd_com);
        end
        f = cyc;
        rst = 1'b1;
        #1;
        checks++;
        if (fnd_com !== 4'b1111 || fnd_data !== 8'hFF) begin
            errors++;
            $display("FAIL async_reset got com=%b data=%h expected com=1111 data=ff",
                     fnd_com, fnd_data);
        end
        push_blank(f + 1, f + 2);
        wait_cyc(f + 2);
        rst = 1'b0;
        rbase = cyc;
        r2 = cyc;
        push_window(r2 + 1, r2 + 8, 8'h90, 8'h90, 8'hA4, 8'h99);
        wait_cyc(r2 + 9);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations got %0d expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
